// File: rtl/pdua_pkg.sv
// pdua_pkg: shared types and limits for the PDUA interrupt controller.
// Holds FSM state encoding, channel-count bounds and default vector base.
package pdua_pkg;

  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;

  localparam logic [7:0] VEC_BASE_DEF = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/pdua_prio_enc.sv
// pdua_prio_enc: lowest-index-wins priority encoder.
// Ports: req[N] in; idx (index of lowest set bit), vld (any bit set) out.
module pdua_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         vld
);

  // Scan downward so the lowest set bit is the last write.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdua_int_ctrl.sv
// pdua_int_ctrl: prioritized interrupt controller, IDLE->REQ->SERVICE FSM.
// Ports: clk, rst (async low), irq_in, mask_wr/mask_data, int_ack, int_eoi
//   in; int_req, int_vec, int_id, mask_q, busy out.
// Build option PDUA_INT_EDGE_EN: rising-edge pending (ack clears);
//   default build: pending follows the synchronized level.
module pdua_int_ctrl
  import pdua_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int VEC_WIDTH = 8,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE =
    VEC_WIDTH'(VEC_BASE_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         irq_in,
  input  logic                      mask_wr,
  input  logic [NUM_CH-1:0]         mask_data,
  input  logic                      int_ack,
  input  logic                      int_eoi,
  output logic                      int_req,
  output logic [VEC_WIDTH-1:0]      int_vec,
  output logic [$clog2(NUM_CH)-1:0] int_id,
  output logic [NUM_CH-1:0]         mask_q,
  output logic                      busy
);

  localparam int IDW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] eligible;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] id_nxt;
  logic [IDW-1:0] win_idx;
  logic           win_vld;
  logic           req_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '1;
    end else if (mask_wr) begin
      mask_q <= mask_data;
    end
  end

`ifdef PDUA_INT_EDGE_EN
  logic [NUM_CH-1:0] sync_d;
  logic [NUM_CH-1:0] clr;

  always_comb begin
    clr = '0;
    if (state == ST_REQ && int_ack) begin
      clr[id_q] = 1'b1;
    end
  end

  // Set wins over a same-cycle ack clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_d  <= '0;
      pending <= '0;
    end else begin
      sync_d  <= sync2;
      pending <= (pending & ~clr) | (sync2 & ~sync_d);
    end
  end
`else
  assign pending = sync2;
`endif

  assign eligible = pending & ~mask_q;

  pdua_prio_enc #(
    .N (NUM_CH),
    .W (IDW)
  ) u_prio (
    .req (eligible),
    .idx (win_idx),
    .vld (win_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      id_q  <= '0;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      id_q  <= id_nxt;
      req_q <= (state_nxt == ST_REQ);
    end
  end

  // Eligibility is only sampled in IDLE, so masking in REQ cannot
  // withdraw an outstanding request.
  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    unique case (state)
      ST_IDLE: begin
        if (win_vld) begin
          state_nxt = ST_REQ;
          id_nxt    = win_idx;
        end
      end
      ST_REQ: begin
        if (int_ack) state_nxt = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (int_eoi) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign int_req = req_q;
  assign int_id  = id_q;
  assign int_vec = VEC_BASE + VEC_WIDTH'(id_q);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_pdua_int_ctrl.sv
// tb_pdua_int_ctrl: scoreboard bench for pdua_int_ctrl (8 channels).
// Expected grants are queued at stimulus time and popped on int_req.
module tb_pdua_int_ctrl;

`ifdef PDUA_INT_EDGE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq_in = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_data = '0;
  logic       int_ack = 1'b0;
  logic       int_eoi = 1'b0;
  logic       int_req;
  logic [7:0] int_vec;
  logic [2:0] int_id;
  logic [7:0] mask_q;
  logic       busy;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pdua_int_ctrl #(
    .NUM_CH    (8),
    .VEC_WIDTH (8),
    .VEC_BASE  (8'hF0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .int_ack   (int_ack),
    .int_eoi   (int_eoi),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_id    (int_id),
    .mask_q    (mask_q),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_mask(input logic [7:0] m);
    mask_wr   = 1'b1;
    mask_data = m;
    tick();
    mask_wr   = 1'b0;
    check("mask_q", mask_q, m);
  endtask

  // Reference model: eligible channels are granted in ascending order.
  task automatic push_grants(input logic [7:0] bits,
                             input logic [7:0] msk);
    for (int i = 0; i < 8; i++)
      if (bits[i] && !msk[i]) exp_q.push_back(i);
  endtask

  task automatic grant_cmp(input string tag);
    int e;
    logic [7:0] ev;
    check({tag, "_qn"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = 8'hF0 + 8'(e);
      check({tag, "_id"}, int_id, e);
      check({tag, "_vec"}, int_vec, ev);
      check({tag, "_busy"}, busy, 1);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!int_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, int_req, 1);
    if (int_req) grant_cmp(tag);
  endtask

  task automatic ack_seq(input string tag, input logic [7:0] drop);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq_in  = irq_in & ~drop;
    check({tag, "_svc"}, {int_req, busy}, 2'b01);
    idle(4);
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    check("rst_req", int_req, 0);
    check("rst_id", int_id, 0);
    check("rst_vec", int_vec, 8'hF0);
    check("rst_busy", busy, 0);
    check("rst_mask", mask_q, 8'hFF);
    rst = 1'b1;
    tick();

    // Masked source is held off until the mask opens.
    irq_in[0] = 1'b1;
    idle(8);
    check("masked_req", int_req, 0);
    wr_mask(8'hFE);
    push_grants(8'h01, 8'hFE);
    wait_grant("m0");
    ack_seq("m0", 8'h01);
    wr_mask(8'h00);
    idle(2);

    // Single pulse: exact latency and vector.
    irq_in[3] = 1'b1;
    push_grants(8'h08, 8'h00);
    for (int n = 1; n <= LAT; n++) begin
      tick();
      if (n == 1) irq_in[3] = 1'b0;
      if (n == LAT - 1) check("lat_lo", int_req, 0);
    end
    check("lat_hi", int_req, 1);
    grant_cmp("c3");
    for (int k = 0; k < 3; k++) begin
      tick();
      check("c3_hold", {int_req, int_id}, {1'b1, 3'd3});
    end
    ack_seq("c3", 8'h00);
    idle(6);
    check("c3_clr", int_req, 0);

    // Two simultaneous sources: lowest index first.
    irq_in = 8'h24;
    push_grants(8'h24, 8'h00);
    wait_grant("c2");
    ack_seq("c2", 8'h04);
    wait_grant("c5");
    ack_seq("c5", 8'h20);
    idle(2);

    // Masking the granted channel during REQ keeps the request.
    irq_in[1] = 1'b1;
    push_grants(8'h02, 8'h00);
    wait_grant("c1");
    wr_mask(8'h02);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("c1_hold", {int_req, int_id}, {1'b1, 3'd1});
    end
    ack_seq("c1", 8'h02);
    wr_mask(8'h00);
    idle(2);

    // Stray ack/eoi are ignored.
    int_ack = 1'b1;
    int_eoi = 1'b1;
    tick();
    int_ack = 1'b0;
    int_eoi = 1'b0;
    check("idle_ign", busy, 0);
    irq_in[6] = 1'b1;
    push_grants(8'h40, 8'h00);
    wait_grant("c6");
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    check("eoi_ign", int_req, 1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq_in[6] = 1'b0;
    check("c6_svc", {int_req, busy}, 2'b01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ack_ign", {int_req, busy}, 2'b01);
    idle(3);
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    check("c6_idle", busy, 0);
    idle(2);

    // Held level through ack and eoi.
    irq_in[4] = 1'b1;
    push_grants(8'h10, 8'h00);
    wait_grant("c4a");
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    idle(3);
`ifndef PDUA_INT_EDGE_EN
    push_grants(8'h10, 8'h00);
`endif
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    check("c4_idle", busy, 0);
`ifndef PDUA_INT_EDGE_EN
    wait_grant("c4b");
    ack_seq("c4b", 8'h10);
`else
    idle(6);
    check("c4_once", int_req, 0);
    irq_in[4] = 1'b0;
`endif
    idle(4);

    // Reset during SERVICE aborts everything at once.
    irq_in[7] = 1'b1;
    push_grants(8'h80, 8'h00);
    wait_grant("c7");
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq_in[7] = 1'b0;
    check("c7_svc", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_req", int_req, 0);
    check("ar_busy", busy, 0);
    check("ar_id", int_id, 0);
    check("ar_vec", int_vec, 8'hF0);
    check("ar_mask", mask_q, 8'hFF);
    tick();
    rst = 1'b1;
    wr_mask(8'h00);
    idle(10);
    check("rst_quiet", int_req, 0);
    check("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdua_int_ctrl.md
PDUA_INT_CTRL -- requirements
Module: pdua_int_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of interrupt channels (2..16).
REQ-002 SHALL have parameter VEC_WIDTH, default 8, width of the vector output.
REQ-003 SHALL have parameter VEC_BASE, default 8'hF0, vector of channel 0.
REQ-004 SHALL have port clk, input, 1, single system clock (rising edge).
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port irq_in, input, NUM_CH, asynchronous interrupt sources.
REQ-007 SHALL have port mask_wr, input, 1, mask register write strobe.
REQ-008 SHALL have port mask_data, input, NUM_CH, mask write data (1 = masked).
REQ-009 SHALL have port int_ack, input, 1, one-cycle acknowledge from the control unit (int_clr).
REQ-010 SHALL have port int_eoi, input, 1, one-cycle end-of-interrupt pulse.
REQ-011 SHALL have port int_req, output, 1, registered request to the control unit.
REQ-012 SHALL have port int_vec, output, VEC_WIDTH, vector of the granted channel.
REQ-013 SHALL have port int_id, output, $clog2(NUM_CH), index of the granted channel.
REQ-014 SHALL have port mask_q, output, NUM_CH, current mask register.
REQ-015 SHALL have port busy, output, 1, high in REQ or SERVICE.

Function
REQ-016 SHALL pass each irq_in bit through a two-flop synchronizer before any use.
REQ-017 SHALL keep a pending register; a channel is eligible when pending & ~mask_q.
REQ-018 SHALL implement FSM IDLE -> REQ -> SERVICE -> IDLE.
REQ-019 IDLE: if any channel is eligible, latch the lowest-index eligible channel into int_id and go to REQ next edge; else stay.
REQ-020 REQ: int_req = 1 and int_id/int_vec stay stable until int_ack; on int_ack clear the granted pending bit and go to SERVICE.
REQ-021 SERVICE: int_req = 0; on int_eoi go to IDLE; further arbitration starts in the cycle after the IDLE re-entry.
REQ-022 int_vec SHALL equal VEC_BASE + int_id, truncated modulo 2^VEC_WIDTH.
REQ-023 Masking the granted channel while in REQ SHALL NOT withdraw int_req.
REQ-024 A mask write SHALL take effect on the next edge and SHALL NOT alter pending bits.
REQ-025 A set event and an ack-clear on the same channel in the same cycle SHALL leave the bit set.
REQ-026 int_ack outside REQ and int_eoi outside SERVICE SHALL be ignored.

Reset
REQ-027 rst low SHALL immediately force state IDLE, int_req 0, int_id 0, int_vec VEC_BASE, busy 0, pending 0, synchronizers 0, and mask_q all ones.
REQ-028 Reset asserted in REQ or SERVICE SHALL abort the transaction with no residual pending bit.

Configuration
REQ-029 With PDUA_INT_EDGE_EN defined, a rising edge of a synchronized irq_in SHALL set pending, so int_req rises at the 4th rising edge after irq_in is first sampled high.
REQ-030 Without PDUA_INT_EDGE_EN, pending SHALL equal the synchronized level, int_ack SHALL NOT clear it, and int_req SHALL rise at the 3rd edge.

Structure
REQ-031 FSM state encoding, NUM_CH limits and the VEC_BASE default SHALL live in shared package pdua_pkg.
REQ-032 A priority encoder sub-module pdua_prio_enc (NUM_CH to index and valid) SHALL be instantiated.

Verification
REQ-033 Edge mode: mask 8'h00, pulse irq_in[3] -> int_req at 4th edge, int_id 3, int_vec 8'hF3; ack -> SERVICE, pending[3] cleared.
REQ-034 irq_in[5] and irq_in[2] rise together -> grant 2 (vec 8'hF2); after ack and eoi -> grant 5 (vec 8'hF5).
REQ-035 After reset (mask 8'hFF), irq_in[0] pulses -> no int_req; write mask 8'hFE -> int_req, int_id 0.
REQ-036 In REQ for ch1, write mask 8'h02 -> int_req stays 1 until ack.
REQ-037 In SERVICE, drop rst -> all outputs at reset values in the same cycle; after release with irq_in quiet -> int_req stays 0.
REQ-038 Level mode (macro undefined): hold irq_in[4] high through ack and eoi -> re-grant ch4 after returning to IDLE.
